leds_scheduler: RTL

Time-shares the 4-bit board LED bank between up to NUM_REQ requesters (status, error and debug sources) and falls back to an idle pattern, such as the swinger output, when no requester is active. Ownership is granted round-robin. Each owner holds the LEDs for a minimum dwell time and is pre-empted after a timeout when others are waiting. Every ownership change inserts a one-tick all-off gap so handovers are visible. The block sits between the LED pattern sources and the LED pins.

---
 rtl/leds_pkg.sv | 15 +
 rtl/leds_rr_arbiter.sv | 30 +++
 rtl/leds_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/leds_pkg.sv
// Shared types and constants for the LED bank scheduler.
package leds_pkg;
  localparam int LED_WIDTH = 4;
  localparam logic [LED_WIDTH-1:0] LED_OFF = 4'b0000;

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/leds_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after 'last', wrapping.
module leds_rr_arbiter
  import leds_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);
  int idx;

  always_comb begin
    idx     = 0;
    grant   = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!any && req[IDX_W'(idx)]) begin
        any                 = 1'b1;
        grant[IDX_W'(idx)]  = 1'b1;
        win_idx             = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/leds_scheduler.sv
// Time-shares the LED bank between requesters with round-robin ownership,
// minimum dwell, timeout pre-emption and a one-tick dark gap on handover.
module leds_scheduler
  import leds_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TICK_WIDTH    = 24,
  parameter int DWELL_TICKS   = 4,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [LED_WIDTH-1:0]           DEFAULT_DATA,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [LED_WIDTH*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]             GRANT,
  output logic [LED_WIDTH-1:0]           DATA,
  output logic                           BUSY
);
  localparam int IDX_W = clog2(NUM_REQ);
  localparam int DW_W  = clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW_W-1:0] DWELL_MIN = DW_W'(DWELL_TICKS);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(TIMEOUT_TICKS);

  state_e                 state_q, state_d;
  logic [TICK_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic [DW_W-1:0]        dwell_q, dwell_d;
  logic [IDX_W-1:0]       last_q, last_d, owner_q, owner_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [LED_WIDTH-1:0]   data_q, data_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     win_grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any, take, owner_req, others_req, leave;
  logic [LED_WIDTH-1:0]   req_data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_a[i] = REQ_DATA[i*LED_WIDTH +: LED_WIDTH];
  end

  leds_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (REQ),
    .last    (last_q),
    .grant   (win_grant),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // grant_q is the owner's one-hot while OWNED, so masking it leaves the waiters
  assign owner_req  = REQ[owner_q];
  assign others_req = |(REQ & ~grant_q);
  assign leave      = (dwell_q >= DWELL_MIN && !owner_req) ||
                      (dwell_q >= DWELL_MAX && others_req);

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    tick_d  = &cnt_q;
    state_d = state_q;
    dwell_d = dwell_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    busy_d  = busy_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        take    = win_any;
        data_d  = DEFAULT_DATA;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      OWNED: begin
        if (leave) begin
          state_d = GAP;
          grant_d = '0;
          data_d  = LED_OFF;
        end else begin
          if (owner_req) data_d = req_data_a[owner_q];
          if (tick_q && dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        end
      end
      GAP: begin
        if (tick_q) begin
          take    = win_any;
          state_d = IDLE;
          data_d  = DEFAULT_DATA;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = OWNED;
      owner_d = win_idx;
      last_d  = win_idx;
      dwell_d = '0;
      grant_d = win_grant;
      data_d  = req_data_a[win_idx];
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      dwell_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= LED_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      dwell_q <= dwell_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign GRANT = grant_q;
  assign DATA  = data_q;
  assign BUSY  = busy_q;
endmodule
